// File: rtl/lp_perf_timer.sv
// ---------------------------------------------------------------------------
// lp_perf_timer
//
// Multi-channel elapsed-time monitor for the LP accelerator. Each channel
// measures the time between a start pulse and an end pulse in ticks of
// TICK_DIV clk cycles. Software reads the elapsed time, status and number of
// completed runs over an AXI4-Lite slave, and clears a channel by writing 1
// to bit 0 of its STATUS register.
//
// Register map (channel c at 0x10*c):
//   +0x0 ELAPSED (RO)  ticks counted, saturating
//   +0x4 STATUS  (R/W) bit0 running, bit1 done, bit2 ovf; write bit0=1 clears
//   +0x8 RUNS    (RO)  completed runs, saturating
//   +0xC and unmapped addresses read 0. Every response is OKAY.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   S_AXI_*              AXI4-Lite slave (AW/W/B write, AR/R read)
//   lp_start[NUM_CH]     per-channel start pulse
//   lp_end[NUM_CH]       per-channel end pulse
//   lp_done[NUM_CH]      per-channel sticky done flag (same as STATUS.done)
// ---------------------------------------------------------------------------
module lp_perf_timer #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int TICK_DIV = 100,
   parameter int ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              resetn,
   // write address
   input  logic [ADDR_W-1:0] S_AXI_AWADDR,
   input  logic [2:0]        S_AXI_AWPROT,
   input  logic              S_AXI_AWVALID,
   output logic              S_AXI_AWREADY,
   // write data
   input  logic [31:0]       S_AXI_WDATA,
   input  logic [3:0]        S_AXI_WSTRB,
   input  logic              S_AXI_WVALID,
   output logic              S_AXI_WREADY,
   // write response
   output logic [1:0]        S_AXI_BRESP,
   output logic              S_AXI_BVALID,
   input  logic              S_AXI_BREADY,
   // read address
   input  logic [ADDR_W-1:0] S_AXI_ARADDR,
   input  logic [2:0]        S_AXI_ARPROT,
   input  logic              S_AXI_ARVALID,
   output logic              S_AXI_ARREADY,
   // read data
   output logic [31:0]       S_AXI_RDATA,
   output logic [1:0]        S_AXI_RRESP,
   output logic              S_AXI_RVALID,
   input  logic              S_AXI_RREADY,
   // LP datapath events
   input  logic [NUM_CH-1:0] lp_start,
   input  logic [NUM_CH-1:0] lp_end,
   output logic [NUM_CH-1:0] lp_done
);

   // Prescaler counts 1..TICK_DIV, so it needs room for TICK_DIV itself.
   localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
   localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
   localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Word offsets inside a channel's 16-byte window.
   localparam logic [1:0] OFS_ELAPSED = 2'd0;
   localparam logic [1:0] OFS_STATUS  = 2'd1;
   localparam logic [1:0] OFS_RUNS    = 2'd2;

   // ------------------------------------------------------------------------
   // Per-channel views collected for the read mux
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] elapsed_ch [NUM_CH];
   logic [CNT_W-1:0] runs_ch    [NUM_CH];
   logic [2:0]       status_ch  [NUM_CH];

   // ------------------------------------------------------------------------
   // Write path: independent one-entry AW and W holding registers
   // ------------------------------------------------------------------------
   logic              aw_full_reg;
   logic [ADDR_W-1:0] aw_addr_reg;
   logic              w_full_reg;
   logic              w_clr_reg;     // WSTRB[0] & WDATA[0] of the held beat
   logic              bvalid_reg;
   logic              wr_exec;
   logic              wr_is_status;
   logic [ADDR_W-1:0] aw_ch_field;

   // A write executes once both halves are held and no response is pending.
   assign wr_exec      = aw_full_reg & w_full_reg & ~bvalid_reg;
   assign wr_is_status = (aw_addr_reg[3:2] == OFS_STATUS);
   assign aw_ch_field  = aw_addr_reg >> 4;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_full_reg <= 1'b0;
         aw_addr_reg <= '0;
         w_full_reg  <= 1'b0;
         w_clr_reg   <= 1'b0;
         bvalid_reg  <= 1'b0;
      end else begin
         if (S_AXI_AWVALID && !aw_full_reg) begin
            aw_full_reg <= 1'b1;
            aw_addr_reg <= S_AXI_AWADDR;
         end
         if (S_AXI_WVALID && !w_full_reg) begin
            w_full_reg <= 1'b1;
            w_clr_reg  <= S_AXI_WSTRB[0] & S_AXI_WDATA[0];
         end
         // Execution needs both holding registers full, so it can never
         // collide with a new acceptance into the same register.
         if (wr_exec) begin
            aw_full_reg <= 1'b0;
            w_full_reg  <= 1'b0;
            bvalid_reg  <= 1'b1;
         end else if (bvalid_reg && S_AXI_BREADY) begin
            bvalid_reg <= 1'b0;
         end
      end
   end

   assign S_AXI_AWREADY = ~aw_full_reg;
   assign S_AXI_WREADY  = ~w_full_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = 2'b00;

   // ------------------------------------------------------------------------
   // Read path: single outstanding read, data captured at AR acceptance
   // ------------------------------------------------------------------------
   logic              arready_reg;
   logic              rvalid_reg;
   logic [31:0]       rdata_reg;
   logic [31:0]       rd_word;
   logic [ADDR_W-1:0] ar_ch_field;

   assign ar_ch_field = S_AXI_ARADDR >> 4;

   always_comb begin
      rd_word = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ar_ch_field == ADDR_W'(c)) begin
            case (S_AXI_ARADDR[3:2])
               OFS_ELAPSED: rd_word = 32'(elapsed_ch[c]);
               OFS_STATUS:  rd_word = {29'd0, status_ch[c]};
               OFS_RUNS:    rd_word = 32'(runs_ch[c]);
               default:     rd_word = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arready_reg <= 1'b1;
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         if (S_AXI_ARVALID && arready_reg) begin
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b1;
            rdata_reg   <= rd_word;
         end else if (rvalid_reg && S_AXI_RREADY) begin
            // RDATA keeps its last value; only the valid flag drops.
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
         end
      end
   end

   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RDATA   = rdata_reg;
   assign S_AXI_RRESP   = 2'b00;

   // ------------------------------------------------------------------------
   // Timer channels
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             running_reg, running_next;
         logic             done_reg, done_next;
         logic             ovf_reg, ovf_next;
         logic [CNT_W-1:0] elapsed_reg, elapsed_next;
         logic [CNT_W-1:0] runs_reg, runs_next;
         logic [PRE_W-1:0] presc_reg, presc_next;
         logic             clear_hit;

         assign clear_hit = wr_exec & w_clr_reg & wr_is_status &
                            (aw_ch_field == ADDR_W'(gi));

         always_comb begin
            running_next = running_reg;
            done_next    = done_reg;
            ovf_next     = ovf_reg;
            elapsed_next = elapsed_reg;
            runs_next    = runs_reg;
            presc_next   = presc_reg;

            if (clear_hit) begin
               // Software clear takes priority over any same-cycle event.
               running_next = 1'b0;
               done_next    = 1'b0;
               ovf_next     = 1'b0;
               elapsed_next = '0;
               runs_next    = '0;
            end else if (!running_reg) begin
               // Idle: start begins a run (a coincident end is ignored),
               // an end on its own does nothing.
               if (lp_start[gi]) begin
                  running_next = 1'b1;
                  done_next    = 1'b0;
                  ovf_next     = 1'b0;
                  elapsed_next = '0;
                  presc_next   = PRE_ONE;
               end
            end else if (lp_end[gi]) begin
               // Running: end wins over a coincident start.
               running_next = 1'b0;
               done_next    = 1'b1;
               if (runs_reg != CNT_ONES) begin
                  runs_next = runs_reg + CNT_ONE;
               end
            end else if (lp_start[gi]) begin
               // Restart: timing begins again, completed-run count untouched.
               elapsed_next = '0;
               presc_next   = PRE_ONE;
               ovf_next     = 1'b0;
            end else if (presc_reg == PRE_TOP) begin
               presc_next = PRE_ONE;
               if (elapsed_reg == CNT_ONES) begin
                  ovf_next = 1'b1;   // tick lost: hold the count, flag it
               end else begin
                  elapsed_next = elapsed_reg + CNT_ONE;
               end
            end else begin
               presc_next = presc_reg + PRE_ONE;
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               running_reg <= 1'b0;
               done_reg    <= 1'b0;
               ovf_reg     <= 1'b0;
               elapsed_reg <= '0;
               runs_reg    <= '0;
               presc_reg   <= '0;
            end else begin
               running_reg <= running_next;
               done_reg    <= done_next;
               ovf_reg     <= ovf_next;
               elapsed_reg <= elapsed_next;
               runs_reg    <= runs_next;
               presc_reg   <= presc_next;
            end
         end

         assign elapsed_ch[gi] = elapsed_reg;
         assign runs_ch[gi]    = runs_reg;
         assign status_ch[gi]  = {ovf_reg, done_reg, running_reg};
         assign lp_done[gi]    = done_reg;
      end
   endgenerate

   // Protection bits and the upper data/strobe bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB[3:1],
                          S_AXI_WDATA[31:1]};

endmodule

// File: tb/tb_lp_perf_timer.sv
// ---------------------------------------------------------------------------
// Testbench for lp_perf_timer. Two instances share clk/resetn:
//   index 0: NUM_CH=4, CNT_W=32, TICK_DIV=100 (main timing scenarios)
//   index 1: NUM_CH=4, CNT_W=4,  TICK_DIV=1   (saturation scenarios)
// ---------------------------------------------------------------------------
module tb_lp_perf_timer;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   logic [7:0]  awaddr  [2];
   logic [2:0]  awprot  [2];
   logic        awvalid [2];
   logic        awready [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wvalid  [2];
   logic        wready  [2];
   logic [1:0]  bresp   [2];
   logic        bvalid  [2];
   logic        bready  [2];
   logic [7:0]  araddr  [2];
   logic [2:0]  arprot  [2];
   logic        arvalid [2];
   logic        arready [2];
   logic [31:0] rdata   [2];
   logic [1:0]  rresp   [2];
   logic        rvalid  [2];
   logic        rready  [2];
   logic [3:0]  lp_start [2];
   logic [3:0]  lp_end   [2];
   logic [3:0]  lp_done  [2];

   lp_perf_timer #(.NUM_CH(4), .CNT_W(32), .TICK_DIV(100), .ADDR_W(8)) u_main (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(awaddr[0]), .S_AXI_AWPROT(awprot[0]),
      .S_AXI_AWVALID(awvalid[0]), .S_AXI_AWREADY(awready[0]),
      .S_AXI_WDATA(wdata[0]), .S_AXI_WSTRB(wstrb[0]),
      .S_AXI_WVALID(wvalid[0]), .S_AXI_WREADY(wready[0]),
      .S_AXI_BRESP(bresp[0]), .S_AXI_BVALID(bvalid[0]), .S_AXI_BREADY(bready[0]),
      .S_AXI_ARADDR(araddr[0]), .S_AXI_ARPROT(arprot[0]),
      .S_AXI_ARVALID(arvalid[0]), .S_AXI_ARREADY(arready[0]),
      .S_AXI_RDATA(rdata[0]), .S_AXI_RRESP(rresp[0]),
      .S_AXI_RVALID(rvalid[0]), .S_AXI_RREADY(rready[0]),
      .lp_start(lp_start[0]), .lp_end(lp_end[0]), .lp_done(lp_done[0])
   );

   lp_perf_timer #(.NUM_CH(4), .CNT_W(4), .TICK_DIV(1), .ADDR_W(8)) u_sat (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(awaddr[1]), .S_AXI_AWPROT(awprot[1]),
      .S_AXI_AWVALID(awvalid[1]), .S_AXI_AWREADY(awready[1]),
      .S_AXI_WDATA(wdata[1]), .S_AXI_WSTRB(wstrb[1]),
      .S_AXI_WVALID(wvalid[1]), .S_AXI_WREADY(wready[1]),
      .S_AXI_BRESP(bresp[1]), .S_AXI_BVALID(bvalid[1]), .S_AXI_BREADY(bready[1]),
      .S_AXI_ARADDR(araddr[1]), .S_AXI_ARPROT(arprot[1]),
      .S_AXI_ARVALID(arvalid[1]), .S_AXI_ARREADY(arready[1]),
      .S_AXI_RDATA(rdata[1]), .S_AXI_RRESP(rresp[1]),
      .S_AXI_RVALID(rvalid[1]), .S_AXI_RREADY(rready[1]),
      .lp_start(lp_start[1]), .lp_end(lp_end[1]), .lp_done(lp_done[1])
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("ok   %-16s = 0x%08h", name, act);
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // All tasks are entered and left on a falling edge.
   task automatic pulse(input int d, input logic [3:0] s, input logic [3:0] e);
      lp_start[d] = s;
      lp_end[d]   = e;
      @(negedge clk);
      lp_start[d] = '0;
      lp_end[d]   = '0;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic axi_read(input int d, input logic [7:0] addr,
                           output logic [31:0] data, output logic [1:0] resp);
      int n;
      araddr[d]  = addr;
      arvalid[d] = 1'b1;
      rready[d]  = 1'b1;
      n = 0;
      while (!arready[d] && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      arvalid[d] = 1'b0;
      n = 0;
      while (!rvalid[d] && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!rvalid[d]) check("rd_timeout", {31'd0, rvalid[d]}, 32'd1);
      data = rdata[d];
      resp = rresp[d];
      @(negedge clk);
      rready[d] = 1'b0;
   endtask

   task automatic read_check(input int d, input logic [7:0] addr, input logic [31:0] exp);
      logic [31:0] data;
      logic [1:0]  resp;
      axi_read(d, addr, data, resp);
      check($sformatf("rd%0d_%02h", d, addr), data, exp);
   endtask

   task automatic axi_write(input int d, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
      int n;
      awaddr[d]  = addr;
      wdata[d]   = data;
      wstrb[d]   = strb;
      awvalid[d] = 1'b1;
      wvalid[d]  = 1'b1;
      bready[d]  = 1'b1;
      @(negedge clk);
      awvalid[d] = 1'b0;
      wvalid[d]  = 1'b0;
      n = 0;
      while (!bvalid[d] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wr%0d_%02h_bvalid", d, addr), {31'd0, bvalid[d]}, 32'd1);
      @(negedge clk);
      bready[d] = 1'b0;
   endtask

   typedef struct {
      int          d;
      logic [7:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t tbl [17];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] data;
      logic [1:0]  resp;
      int          n;
      int          extra_b;

      // Expected register contents after the first timing scenarios.
      tbl[0]  = '{0, 8'h00, 32'd3};
      tbl[1]  = '{0, 8'h04, 32'h2};
      tbl[2]  = '{0, 8'h08, 32'd1};
      tbl[3]  = '{0, 8'h0C, 32'd0};
      tbl[4]  = '{0, 8'h10, 32'd0};
      tbl[5]  = '{0, 8'h14, 32'd0};
      tbl[6]  = '{0, 8'h18, 32'd0};
      tbl[7]  = '{0, 8'h24, 32'd0};
      tbl[8]  = '{0, 8'h34, 32'd0};
      tbl[9]  = '{0, 8'h40, 32'd0};
      tbl[10] = '{0, 8'hFC, 32'd0};
      tbl[11] = '{1, 8'h10, 32'd15};
      tbl[12] = '{1, 8'h14, 32'h6};
      tbl[13] = '{1, 8'h18, 32'd1};
      tbl[14] = '{1, 8'h20, 32'd0};
      tbl[15] = '{1, 8'h24, 32'h2};
      tbl[16] = '{1, 8'h28, 32'd15};

      for (int d = 0; d < 2; d++) begin
         awaddr[d] = '0; awprot[d] = '0; awvalid[d] = 1'b0;
         wdata[d] = '0;  wstrb[d] = '0;  wvalid[d] = 1'b0; bready[d] = 1'b0;
         araddr[d] = '0; arprot[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
         lp_start[d] = '0; lp_end[d] = '0;
      end

      resetn = 1'b0;
      wait_n(3);
      resetn = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_arready", {31'd0, arready[0]}, 32'd1);
      check("rst_awready", {31'd0, awready[0]}, 32'd1);
      check("rst_wready",  {31'd0, wready[0]},  32'd1);
      check("rst_rvalid",  {31'd0, rvalid[0]},  32'd0);
      check("rst_bvalid",  {31'd0, bvalid[0]},  32'd0);
      check("rst_rdata",   rdata[0], 32'd0);
      check("rst_lp_done", {28'd0, lp_done[0]}, 32'd0);

      // ch0: start, end 350 cycles later -> 3 ticks
      pulse(0, 4'b0001, 4'b0000);
      wait_n(349);
      pulse(0, 4'b0000, 4'b0001);
      check("s1_lp_done", {28'd0, lp_done[0]}, 32'h1);

      // small instance ch1: 20 cycles at one tick per cycle saturates 4 bits
      pulse(1, 4'b0010, 4'b0000);
      wait_n(19);
      pulse(1, 4'b0000, 4'b0010);

      // small instance ch2: 16 completed runs saturate RUNS at 15
      for (int i = 0; i < 16; i++) begin
         pulse(1, 4'b0100, 4'b0000);
         pulse(1, 4'b0000, 4'b0100);
      end
      check("sat_lp_done", {28'd0, lp_done[1]}, 32'h6);

      for (int i = 0; i < 17; i++) begin
         axi_read(tbl[i].d, tbl[i].addr, data, resp);
         check($sformatf("tbl%0d_%02h", tbl[i].d, tbl[i].addr), data, tbl[i].exp);
         check($sformatf("tbl%0d_%02h_resp", tbl[i].d, tbl[i].addr), {30'd0, resp}, 32'd0);
      end

      // ch2: start at E0, live reads, restart at E250, end at E460
      pulse(0, 4'b0100, 4'b0000);
      wait_n(227);
      read_check(0, 8'h20, 32'd2);        // sampled at E228: ticks at E100, E200
      read_check(0, 8'h24, 32'h1);        // running
      wait_n(18);
      pulse(0, 4'b0100, 4'b0000);         // restart at E250
      read_check(0, 8'h20, 32'd0);        // restart cleared the count
      wait_n(207);
      pulse(0, 4'b0000, 4'b0100);         // end at E460: ticks at E350, E450
      read_check(0, 8'h20, 32'd2);
      read_check(0, 8'h28, 32'd1);
      read_check(0, 8'h24, 32'h2);

      // ch3: start+end while idle starts; start+end while running ends;
      // end alone while idle does nothing
      pulse(0, 4'b1000, 4'b1000);
      read_check(0, 8'h34, 32'h1);
      pulse(0, 4'b1000, 4'b1000);
      pulse(0, 4'b0000, 4'b1000);
      read_check(0, 8'h34, 32'h2);
      read_check(0, 8'h38, 32'd1);

      // Read held by RREADY low for 5 cycles
      araddr[0]  = 8'h00;
      arvalid[0] = 1'b1;
      rready[0]  = 1'b0;
      @(negedge clk);
      arvalid[0] = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("hold%0d_rvalid", k),  {31'd0, rvalid[0]},  32'd1);
         check($sformatf("hold%0d_rdata", k),   rdata[0], 32'd3);
         check($sformatf("hold%0d_arready", k), {31'd0, arready[0]}, 32'd0);
         if (k < 5) @(negedge clk);
      end
      rready[0] = 1'b1;
      @(negedge clk);
      rready[0] = 1'b0;
      check("hold_done_rvalid",  {31'd0, rvalid[0]},  32'd0);
      check("hold_done_arready", {31'd0, arready[0]}, 32'd1);

      // ch1: one short run, then clear with W arriving 3 cycles before AW
      pulse(0, 4'b0010, 4'b0000);
      wait_n(150);
      pulse(0, 4'b0000, 4'b0010);
      read_check(0, 8'h10, 32'd1);
      read_check(0, 8'h14, 32'h2);
      wdata[0]  = 32'h1;
      wstrb[0]  = 4'hF;
      wvalid[0] = 1'b1;
      bready[0] = 1'b0;
      @(negedge clk);
      wvalid[0] = 1'b0;
      check("w_only_wready", {31'd0, wready[0]}, 32'd0);
      check("w_only_bvalid", {31'd0, bvalid[0]}, 32'd0);
      wait_n(2);
      awaddr[0]  = 8'h14;
      awvalid[0] = 1'b1;
      @(negedge clk);
      awvalid[0] = 1'b0;
      n = 0;
      while (!bvalid[0] && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("clr_bvalid", {31'd0, bvalid[0]}, 32'd1);
      check("clr_bresp",  {30'd0, bresp[0]},  32'd0);
      @(negedge clk);
      check("clr_bvalid_held", {31'd0, bvalid[0]}, 32'd1);
      bready[0] = 1'b1;
      @(negedge clk);
      bready[0] = 1'b0;
      extra_b = 0;
      for (int k = 0; k < 5; k++) begin
         if (bvalid[0]) extra_b++;
         @(negedge clk);
      end
      check("clr_single_b", extra_b, 32'd0);
      check("clr_awready", {31'd0, awready[0]}, 32'd1);
      check("clr_wready",  {31'd0, wready[0]},  32'd1);
      read_check(0, 8'h10, 32'd0);
      read_check(0, 8'h14, 32'd0);
      read_check(0, 8'h18, 32'd0);
      check("clr_lp_done", {28'd0, lp_done[0]}, 32'hD);

      // Writes that must be ignored
      axi_write(0, 8'h04, 32'h1, 4'h0);   // strobe off
      axi_write(0, 8'h04, 32'h0, 4'hF);   // clear bit 0
      axi_write(0, 8'h00, 32'h1, 4'hF);   // read-only register
      axi_write(0, 8'h08, 32'h1, 4'hF);   // read-only register
      read_check(0, 8'h00, 32'd3);
      read_check(0, 8'h04, 32'h2);
      read_check(0, 8'h08, 32'd1);

      // Clear of ch3 on the same cycle as a start: clear wins
      awaddr[0]  = 8'h34;
      wdata[0]   = 32'h1;
      wstrb[0]   = 4'h1;
      awvalid[0] = 1'b1;
      wvalid[0]  = 1'b1;
      bready[0]  = 1'b1;
      @(negedge clk);                     // both halves held
      awvalid[0]  = 1'b0;
      wvalid[0]   = 1'b0;
      lp_start[0] = 4'b1000;
      @(negedge clk);                     // write executes with start present
      lp_start[0] = 4'b0000;
      check("race_bvalid", {31'd0, bvalid[0]}, 32'd1);
      @(negedge clk);
      bready[0] = 1'b0;
      read_check(0, 8'h34, 32'h0);
      read_check(0, 8'h38, 32'd0);

      // Reset during a run and with a read response pending
      pulse(0, 4'b0001, 4'b0000);
      araddr[0]  = 8'h00;
      arvalid[0] = 1'b1;
      rready[0]  = 1'b0;
      @(negedge clk);
      arvalid[0] = 1'b0;
      check("pre_rst_rvalid", {31'd0, rvalid[0]}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_rvalid",   {31'd0, rvalid[0]},  32'd0);
      check("mid_rst_arready",  {31'd0, arready[0]}, 32'd1);
      check("mid_rst_rdata",    rdata[0], 32'd0);
      check("mid_rst_done0",    {28'd0, lp_done[0]}, 32'd0);
      check("mid_rst_done1",    {28'd0, lp_done[1]}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      read_check(0, 8'h00, 32'd0);
      read_check(0, 8'h04, 32'h0);
      read_check(0, 8'h08, 32'd0);
      read_check(1, 8'h28, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
